// File: rtl/hpu_seq_ctrl_pkg.sv
// Shared types and constants for the HPU phase sequencer.
package hpu_seq_ctrl_pkg;

  // Sequencer states; the encoding is visible to software through state_o.
  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    GEN   = 3'd1,
    RUN   = 3'd2,
    DRAIN = 3'd3,
    DONE  = 3'd4
  } state_t;

  // Bit positions inside the sticky error vector.
  localparam int ERR_CMD = 0;
  localparam int ERR_CFG = 1;
  localparam int ERR_TMO = 2;

  // Default widths.
  localparam int unsigned HPU_ITEM_W = 16;
  localparam int unsigned HPU_ADDR_W = 20;
  localparam int unsigned HPU_CYC_W  = 32;
  localparam int unsigned HPU_TMO_W  = 24;

endpackage

// File: rtl/hpu_seq_ctrl_if.sv
// Command/config/status bundle between the register block and the sequencer.
interface hpu_seq_ctrl_if
  import hpu_seq_ctrl_pkg::*;
#(
  parameter int unsigned ITEM_W = HPU_ITEM_W,
  parameter int unsigned ADDR_W = HPU_ADDR_W,
  parameter int unsigned CYC_W  = HPU_CYC_W
) ();

  logic              cmd_gen;
  logic              cmd_run;
  logic              cmd_abort;
  logic              clr_err;
  logic [ITEM_W-1:0] cfg_items;
  logic [ADDR_W-1:0] cfg_addr_i;
  logic [ADDR_W-1:0] cfg_addr_j;
  logic              get_fin;
  logic              out_fire;
  logic              out_last;

  logic              gen;
  logic              run;
  logic [ITEM_W-1:0] item_a;
  logic [ADDR_W-1:0] addr_i;
  logic [ADDR_W-1:0] addr_j;
  logic [2:0]        state_o;
  logic              mem_valid;
  logic              done;
  logic [2:0]        err;
  logic [CYC_W-1:0]  run_cycles;

  // Register-block / stream side.
  modport master (
    output cmd_gen, cmd_run, cmd_abort, clr_err,
    output cfg_items, cfg_addr_i, cfg_addr_j,
    output get_fin, out_fire, out_last,
    input  gen, run, item_a, addr_i, addr_j, state_o,
    input  mem_valid, done, err, run_cycles
  );

  // Sequencer side.
  modport slave (
    input  cmd_gen, cmd_run, cmd_abort, clr_err,
    input  cfg_items, cfg_addr_i, cfg_addr_j,
    input  get_fin, out_fire, out_last,
    output gen, run, item_a, addr_i, addr_j, state_o,
    output mem_valid, done, err, run_cycles
  );

endinterface

// File: rtl/hpu_seq_ctrl_wdog.sv
// RUN/DRAIN watchdog: saturating cycle counter with synchronous clear.
module hpu_seq_wdog #(
  parameter int unsigned TMO_W = 24
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expired
);

  // expired flags the cycle that is the (2**TMO_W-1)-th enabled cycle, so the
  // sequencer leaves RUN/DRAIN after exactly that many cycles.
  localparam logic [TMO_W-1:0] LAST = {{(TMO_W-1){1'b1}}, 1'b0};

  logic [TMO_W-1:0] cnt;

  // Count enabled cycles, holding at all-ones.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt <= '0;
    end else if (en && (cnt != '1)) begin
      cnt <= cnt + TMO_W'(1);
    end
  end

  assign expired = en && (cnt >= LAST);

endmodule

// File: rtl/hpu_seq_ctrl.sv
// HPU phase sequencer: item generation -> encode run -> stream drain.
module hpu_seq_ctrl
  import hpu_seq_ctrl_pkg::*;
#(
  parameter int unsigned ITEM_W = HPU_ITEM_W,
  parameter int unsigned ADDR_W = HPU_ADDR_W,
  parameter int unsigned CYC_W  = HPU_CYC_W,
  parameter int unsigned TMO_W  = HPU_TMO_W
) (
  input logic           clk,
  input logic           rst,
  hpu_seq_ctrl_if.slave bus
);

  state_t            state;
  logic              gen_q;
  logic              run_q;
  logic [ITEM_W-1:0] item_a_q;
  logic [ITEM_W-1:0] items_q;
  logic [ADDR_W-1:0] addr_i_q;
  logic [ADDR_W-1:0] addr_j_q;
  logic              mem_valid_q;
  logic              done_q;
  logic [2:0]        err_q;
  logic [CYC_W-1:0]  run_cycles_q;

  logic [2:0]        err_set;
  logic              run_start;
  logic              wdog_en;
  logic              wdog_expired;
  logic              fire_last;

  assign fire_last = bus.out_fire && bus.out_last;
  assign wdog_en   = (state == RUN) || (state == DRAIN);

  // Run acceptance and error sources for this cycle.
  always_comb begin
    run_start = 1'b0;
    err_set   = '0;
    if ((state != IDLE) && (bus.cmd_gen || bus.cmd_run)) begin
      err_set[ERR_CMD] = 1'b1;
    end
    if ((state == IDLE) && !bus.cmd_abort) begin
      if (bus.cmd_gen && bus.cmd_run) begin
        err_set[ERR_CMD] = 1'b1;
      end
      if (bus.cmd_gen && (bus.cfg_items == '0)) begin
        err_set[ERR_CFG] = 1'b1;
      end
      if (!bus.cmd_gen && bus.cmd_run) begin
        if (!mem_valid_q || (bus.cfg_addr_j > bus.cfg_addr_i)) begin
          err_set[ERR_CFG] = 1'b1;
        end else begin
          run_start = 1'b1;
        end
      end
    end
    if (wdog_expired && !bus.cmd_abort) begin
      err_set[ERR_TMO] = 1'b1;
    end
  end

  hpu_seq_wdog #(
    .TMO_W (TMO_W)
  ) u_wdog (
    .clk     (clk),
    .rst     (rst),
    .clr     (run_start),
    .en      (wdog_en),
    .expired (wdog_expired)
  );

  // Phase FSM with all outputs registered.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      gen_q        <= 1'b0;
      run_q        <= 1'b0;
      item_a_q     <= '0;
      items_q      <= '0;
      addr_i_q     <= '0;
      addr_j_q     <= '0;
      mem_valid_q  <= 1'b0;
      done_q       <= 1'b0;
      err_q        <= '0;
      run_cycles_q <= '0;
    end else begin
      done_q <= 1'b0;
      // Clear first, then OR in new errors so a same-cycle error survives clr_err.
      err_q  <= (bus.clr_err ? 3'b000 : err_q) | err_set;
      if (bus.cmd_abort) begin
        if (state == GEN) begin
          mem_valid_q <= 1'b0;
        end
        gen_q <= 1'b0;
        run_q <= 1'b0;
        state <= IDLE;
      end else begin
        case (state)
          IDLE: begin
            if (bus.cmd_gen) begin
              if (bus.cfg_items != '0) begin
                items_q     <= bus.cfg_items;
                item_a_q    <= '0;
                mem_valid_q <= 1'b0;
                gen_q       <= 1'b1;
                state       <= GEN;
              end
            end else if (run_start) begin
              addr_i_q     <= bus.cfg_addr_i;
              addr_j_q     <= bus.cfg_addr_j;
              run_cycles_q <= '0;
              run_q        <= 1'b1;
              state        <= RUN;
            end
          end
          GEN: begin
            if (item_a_q == (items_q - ITEM_W'(1))) begin
              gen_q       <= 1'b0;
              mem_valid_q <= 1'b1;
              state       <= IDLE;
            end else begin
              item_a_q <= item_a_q + ITEM_W'(1);
            end
          end
          RUN, DRAIN: begin
            if (run_cycles_q != '1) begin
              run_cycles_q <= run_cycles_q + CYC_W'(1);
            end
            if (wdog_expired) begin
              run_q <= 1'b0;
              state <= IDLE;
            end else if (((state == RUN) && bus.get_fin && fire_last) ||
                         ((state == DRAIN) && fire_last)) begin
              run_q  <= 1'b0;
              done_q <= 1'b1;
              state  <= DONE;
            end else if ((state == RUN) && bus.get_fin) begin
              state <= DRAIN;
            end
          end
          DONE: begin
            state <= IDLE;
          end
          default: begin
            gen_q <= 1'b0;
            run_q <= 1'b0;
            state <= IDLE;
          end
        endcase
      end
    end
  end

  assign bus.gen        = gen_q;
  assign bus.run        = run_q;
  assign bus.item_a     = item_a_q;
  assign bus.addr_i     = addr_i_q;
  assign bus.addr_j     = addr_j_q;
  assign bus.state_o    = state;
  assign bus.mem_valid  = mem_valid_q;
  assign bus.done       = done_q;
  assign bus.err        = err_q;
  assign bus.run_cycles = run_cycles_q;

endmodule

// File: tb/tb_hpu_seq_ctrl.sv
// Directed bench for hpu_seq_ctrl: default watchdog instance plus a TMO_W=4 instance.
module tb_hpu_seq_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;

  always #5 clk = ~clk;

  hpu_seq_ctrl_if #(.ITEM_W(16), .ADDR_W(20), .CYC_W(32)) bus_a ();
  hpu_seq_ctrl_if #(.ITEM_W(16), .ADDR_W(20), .CYC_W(32)) bus_b ();

  hpu_seq_ctrl #(.ITEM_W(16), .ADDR_W(20), .CYC_W(32), .TMO_W(24)) dut_a (
    .clk (clk),
    .rst (rst),
    .bus (bus_a)
  );

  hpu_seq_ctrl #(.ITEM_W(16), .ADDR_W(20), .CYC_W(32), .TMO_W(4)) dut_b (
    .clk (clk),
    .rst (rst),
    .bus (bus_b)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, got, got, exp, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_gen_a_end(input int unsigned max);
    for (int unsigned i = 0; i < max && bus_a.gen; i++) tick();
    chk("a_gen_end", 32'(bus_a.gen), 32'd0);
  endtask

  initial begin
    int unsigned k;
    int unsigned bad_idx;
    int unsigned n_done;

    bus_a.cmd_gen = 0; bus_a.cmd_run = 0; bus_a.cmd_abort = 0; bus_a.clr_err = 0;
    bus_a.cfg_items = 0; bus_a.cfg_addr_i = 0; bus_a.cfg_addr_j = 0;
    bus_a.get_fin = 0; bus_a.out_fire = 0; bus_a.out_last = 0;
    bus_b.cmd_gen = 0; bus_b.cmd_run = 0; bus_b.cmd_abort = 0; bus_b.clr_err = 0;
    bus_b.cfg_items = 0; bus_b.cfg_addr_i = 0; bus_b.cfg_addr_j = 0;
    bus_b.get_fin = 0; bus_b.out_fire = 0; bus_b.out_last = 0;

    tick(); tick();
    rst = 1'b0;
    tick();
    chk("rst_state", 32'(bus_a.state_o), 32'd0);
    chk("rst_gen", 32'(bus_a.gen), 32'd0);
    chk("rst_run", 32'(bus_a.run), 32'd0);
    chk("rst_done", 32'(bus_a.done), 32'd0);
    chk("rst_mem_valid", 32'(bus_a.mem_valid), 32'd0);
    chk("rst_item_a", 32'(bus_a.item_a), 32'd0);
    chk("rst_err", 32'(bus_a.err), 32'd0);
    chk("rst_run_cycles", bus_a.run_cycles, 32'd0);
    chk("rst_addr_i", 32'(bus_a.addr_i), 32'd0);

    // Run with no generated item set.
    bus_a.cfg_addr_i = 10; bus_a.cfg_addr_j = 2;
    bus_a.cmd_run = 1; tick(); bus_a.cmd_run = 0;
    chk("nogen_err", 32'(bus_a.err), 32'b010);
    chk("nogen_run", 32'(bus_a.run), 32'd0);
    chk("nogen_state", 32'(bus_a.state_o), 32'd0);
    bus_a.clr_err = 1; tick(); bus_a.clr_err = 0;
    chk("clr_err", 32'(bus_a.err), 32'd0);

    // 1000-item generation.
    bus_a.cfg_items = 1000;
    bus_a.cmd_gen = 1; tick(); bus_a.cmd_gen = 0;
    chk("g1k_state", 32'(bus_a.state_o), 32'd1);
    chk("g1k_mv_low", 32'(bus_a.mem_valid), 32'd0);
    k = 0; bad_idx = 0;
    while (bus_a.gen && k < 2000) begin
      if (bus_a.item_a != 16'(k)) bad_idx++;
      k++;
      tick();
    end
    chk("g1k_cycles", k, 32'd1000);
    chk("g1k_bad_idx", bad_idx, 32'd0);
    chk("g1k_item_last", 32'(bus_a.item_a), 32'd999);
    chk("g1k_mem_valid", 32'(bus_a.mem_valid), 32'd1);
    chk("g1k_state_end", 32'(bus_a.state_o), 32'd0);

    // 8 items, then a run with get_fin at cycle 50 and last beat at cycle 60.
    bus_a.cfg_items = 8;
    bus_a.cmd_gen = 1; tick(); bus_a.cmd_gen = 0;
    wait_gen_a_end(20);
    chk("g8_item_last", 32'(bus_a.item_a), 32'd7);
    bus_a.cfg_addr_i = 299; bus_a.cfg_addr_j = 2;
    bus_a.cmd_run = 1; tick(); bus_a.cmd_run = 0;
    chk("run_state", 32'(bus_a.state_o), 32'd2);
    chk("run_high", 32'(bus_a.run), 32'd1);
    chk("run_gen_excl", 32'(bus_a.gen), 32'd0);
    chk("run_addr_i", 32'(bus_a.addr_i), 32'd299);
    chk("run_addr_j", 32'(bus_a.addr_j), 32'd2);
    chk("run_cyc0", bus_a.run_cycles, 32'd0);
    bus_a.cfg_addr_i = 5; bus_a.cfg_addr_j = 1;
    for (int i = 0; i < 50; i++) tick();
    chk("run_cfg_held", 32'(bus_a.addr_i), 32'd299);
    bus_a.get_fin = 1; tick(); bus_a.get_fin = 0;
    chk("drain_state", 32'(bus_a.state_o), 32'd3);
    bus_a.out_fire = 1; tick(); bus_a.out_fire = 0;
    chk("drain_nolast", 32'(bus_a.state_o), 32'd3);
    for (int i = 0; i < 8; i++) tick();
    bus_a.out_fire = 1; bus_a.out_last = 1; tick();
    bus_a.out_fire = 0; bus_a.out_last = 0;
    chk("done_pulse", 32'(bus_a.done), 32'd1);
    chk("done_run_low", 32'(bus_a.run), 32'd0);
    chk("done_state", 32'(bus_a.state_o), 32'd4);
    chk("done_run_cycles", bus_a.run_cycles, 32'd61);
    tick();
    chk("done_one_cycle", 32'(bus_a.done), 32'd0);
    chk("done_to_idle", 32'(bus_a.state_o), 32'd0);
    chk("done_mv_kept", 32'(bus_a.mem_valid), 32'd1);

    // cmd_run during RUN is ignored and flagged; abort leaves mem_valid.
    bus_a.cfg_addr_i = 100; bus_a.cfg_addr_j = 3;
    bus_a.cmd_run = 1; tick();
    chk("rerun_state", 32'(bus_a.state_o), 32'd2);
    tick(); bus_a.cmd_run = 0;
    chk("rerun_ignored", 32'(bus_a.state_o), 32'd2);
    chk("rerun_err", 32'(bus_a.err), 32'b001);
    bus_a.cmd_abort = 1; tick(); bus_a.cmd_abort = 0;
    chk("rabort_state", 32'(bus_a.state_o), 32'd0);
    chk("rabort_run", 32'(bus_a.run), 32'd0);
    chk("rabort_done", 32'(bus_a.done), 32'd0);
    chk("rabort_mv", 32'(bus_a.mem_valid), 32'd1);
    bus_a.clr_err = 1; tick(); bus_a.clr_err = 0;

    // Abort at item_a=5 during GEN.
    bus_a.cfg_items = 20;
    bus_a.cmd_gen = 1; tick(); bus_a.cmd_gen = 0;
    for (int i = 0; i < 5; i++) tick();
    chk("gabort_item5", 32'(bus_a.item_a), 32'd5);
    bus_a.cmd_abort = 1; tick(); bus_a.cmd_abort = 0;
    chk("gabort_gen", 32'(bus_a.gen), 32'd0);
    chk("gabort_state", 32'(bus_a.state_o), 32'd0);
    chk("gabort_mv", 32'(bus_a.mem_valid), 32'd0);
    chk("gabort_done", 32'(bus_a.done), 32'd0);
    tick();
    chk("gabort_done2", 32'(bus_a.done), 32'd0);

    // cmd_gen and cmd_run together: generation wins.
    bus_a.cfg_items = 3;
    bus_a.cmd_gen = 1; bus_a.cmd_run = 1; tick();
    bus_a.cmd_gen = 0; bus_a.cmd_run = 0;
    chk("both_state", 32'(bus_a.state_o), 32'd1);
    chk("both_gen", 32'(bus_a.gen), 32'd1);
    chk("both_err", 32'(bus_a.err), 32'b001);
    wait_gen_a_end(10);
    chk("both_mv", 32'(bus_a.mem_valid), 32'd1);

    // New error in the clr_err cycle survives; zero-item gen rejected.
    bus_a.cfg_items = 0;
    bus_a.clr_err = 1; bus_a.cmd_gen = 1; tick();
    bus_a.clr_err = 0; bus_a.cmd_gen = 0;
    chk("clr_race_err", 32'(bus_a.err), 32'b010);
    chk("zero_items_state", 32'(bus_a.state_o), 32'd0);
    bus_a.clr_err = 1; tick(); bus_a.clr_err = 0;

    // addr_j > addr_i rejected, addr_j == addr_i accepted.
    bus_a.cfg_addr_i = 3; bus_a.cfg_addr_j = 4;
    bus_a.cmd_run = 1; tick(); bus_a.cmd_run = 0;
    chk("badaddr_err", 32'(bus_a.err), 32'b010);
    chk("badaddr_run", 32'(bus_a.run), 32'd0);
    bus_a.cfg_addr_j = 3;
    bus_a.cmd_run = 1; tick(); bus_a.cmd_run = 0;
    chk("eqaddr_state", 32'(bus_a.state_o), 32'd2);
    bus_a.cmd_abort = 1; tick(); bus_a.cmd_abort = 0;

    // Watchdog on the TMO_W=4 instance.
    bus_b.cfg_items = 2;
    bus_b.cmd_gen = 1; tick(); bus_b.cmd_gen = 0;
    tick(); tick();
    chk("b_mv", 32'(bus_b.mem_valid), 32'd1);
    bus_b.cfg_addr_i = 4; bus_b.cfg_addr_j = 1;
    bus_b.cmd_run = 1; tick(); bus_b.cmd_run = 0;
    k = 0; n_done = 0;
    while (bus_b.run && k < 100) begin
      k++;
      tick();
      if (bus_b.done) n_done++;
    end
    tick();
    if (bus_b.done) n_done++;
    chk("tmo_run_cycles_seen", k, 32'd15);
    chk("tmo_err", 32'(bus_b.err), 32'b100);
    chk("tmo_state", 32'(bus_b.state_o), 32'd0);
    chk("tmo_no_done", n_done, 32'd0);
    chk("tmo_run_cycles", bus_b.run_cycles, 32'd15);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
